// File: rtl/mem_access_ctrl.sv
// Load/store front end: runs one req/ack data-memory transaction per request,
// builds byte enables and lane-replicated store data, and stalls the pipeline until it ends.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size_in,
  input  logic        sign_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] rdata_out,
  output logic [31:0] addr_out,
  output logic [1:0]  size_out,
  output logic        sign_out,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] tcnt_reg;
  logic [31:0]   addr_reg;
  logic [1:0]    size_reg;
  logic          sign_reg;

  logic        misaligned;
  logic        valid_req;
  logic        bad_req;
  logic        timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  always_comb begin
    misaligned = ((size_in == 2'b01) && addr_in[0]) ||
                 (size_in[1] && (addr_in[1:0] != 2'b00));
    valid_req  = (mem_read ^ mem_write) && !misaligned;
    bad_req    = (mem_read && mem_write) || ((mem_read || mem_write) && misaligned);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_reg == T_LAST);
    be_next    = 4'b1111;
    wdata_next = wdata_in;
    case (size_in)
      2'b00: begin
        be_next    = 4'b0001 << addr_in[1:0];
        wdata_next = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {addr_in[1], 1'b0};
        wdata_next = {2{wdata_in[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata_in;
      end
    endcase
  end

  // Stall must rise in the very IDLE cycle the request appears, so it is not registered.
  assign stall = !rst && (((state_reg == IDLE) && valid_req) || (state_reg == REQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      tcnt_reg   <= '0;
      addr_reg   <= '0;
      size_reg   <= '0;
      sign_reg   <= 1'b0;
      load_valid <= 1'b0;
      rdata_out  <= '0;
      addr_out   <= '0;
      size_out   <= '0;
      sign_out   <= 1'b0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      load_valid <= 1'b0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid_req) begin
            addr_reg  <= addr_in;
            size_reg  <= size_in;
            sign_reg  <= sign_in;
            mem_we    <= mem_write;
            mem_addr  <= {addr_in[31:2], 2'b00};
            mem_be    <= be_next;
            mem_wdata <= wdata_next;
            mem_req   <= 1'b1;
            tcnt_reg  <= '0;
            state_reg <= REQ;
          end else if (bad_req) begin
            addr_err <= 1'b1;
          end
        end
        REQ: begin
          // An ack arriving in the final timeout cycle still completes normally.
          if (mem_ack) begin
            if (!mem_we) begin
              rdata_out  <= mem_rdata;
              addr_out   <= addr_reg;
              size_out   <= size_reg;
              sign_out   <= sign_reg;
              load_valid <= 1'b1;
            end
            mem_req   <= 1'b0;
            state_reg <= DONE;
          end else if (timeout_hit) begin
            bus_err   <= 1'b1;
            mem_req   <= 1'b0;
            state_reg <= DONE;
          end else begin
            tcnt_reg <= tcnt_reg + CW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and random load/store transactions against a transaction-level model of the controller.
module tb_mem_access_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, sign_in, mem_ack;
  logic [1:0]  size_in;
  logic [31:0] addr_in, wdata_in, mem_rdata;
  logic        stall, load_valid, addr_err, bus_err, mem_req, mem_we, sign_out;
  logic [31:0] rdata_out, addr_out, mem_addr, mem_wdata;
  logic [1:0]  size_out;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the externally visible held state.
  logic [31:0] m_rdata, m_addr_out, m_maddr, m_wd;
  logic [1:0]  m_size;
  logic        m_sign, m_we;
  logic [3:0]  m_be;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .size_in(size_in), .sign_in(sign_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .stall(stall), .load_valid(load_valid), .rdata_out(rdata_out), .addr_out(addr_out),
    .size_out(size_out), .sign_out(sign_out), .addr_err(addr_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit legal(input logic rd, wr, input logic [1:0] sz, input logic [31:0] ad);
    return (rd != wr) && ((ad % nbytes(sz)) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] ad);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << (ad % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r = '0;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % n)*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    m_rdata = '0; m_addr_out = '0; m_maddr = '0; m_wd = '0;
    m_size = '0; m_sign = 1'b0; m_we = 1'b0; m_be = '0;
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_maddr"}, mem_addr, m_maddr);
    chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, m_be});
    chk({tag, "_wd"}, mem_wdata, m_wd);
    chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, m_we});
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  // ack_cycle: REQ cycle (1-based) in which mem_ack is raised, 0 = never.
  // rst_cycle: REQ cycle in which an asynchronous reset is applied, 0 = none.
  task automatic access(input logic rd, wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, wd, rdv, input int ack_cycle, input int rst_cycle);
    bit ok, tmo;
    int nreq;
    mem_read = rd; mem_write = wr; size_in = sz; sign_in = sg;
    addr_in = ad; wdata_in = wd; mem_rdata = rdv; mem_ack = 1'b0;
    ok = legal(rd, wr, sz, ad);
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, {31'd0, ok});
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    if (!ok) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk("addr_err_pulse", {31'd0, addr_err}, 32'd1);
      chk("err_req", {31'd0, mem_req}, 32'd0);
      chk("err_stall", {31'd0, stall}, 32'd0);
      chk_held("err");
      @(posedge clk); #1;
      @(negedge clk);
      chk("addr_err_end", {31'd0, addr_err}, 32'd0);
      @(posedge clk); #1;
      return;
    end
    m_maddr = {ad[31:2], 2'b00}; m_be = exp_be(sz, ad); m_wd = exp_wd(sz, wd); m_we = wr;
    tmo  = !(ack_cycle >= 1 && ack_cycle <= TMO);
    nreq = tmo ? TMO : ack_cycle;
    for (int k = 1; k <= nreq; k++) begin
      @(posedge clk); #1;
      mem_ack = (k == ack_cycle);
      @(negedge clk);
      chk("req_req", {31'd0, mem_req}, 32'd1);
      chk("req_stall", {31'd0, stall}, 32'd1);
      chk_held("req");
      if (k == rst_cycle) begin
        #1 rst = 1'b1;
        #1;
        model_clear();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_lv", {31'd0, load_valid}, 32'd0);
        chk_held("rst");
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    if (rd && !tmo) begin
      m_rdata = rdv; m_addr_out = ad; m_size = sz; m_sign = sg;
    end
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_req", {31'd0, mem_req}, 32'd0);
    chk("done_lv", {31'd0, load_valid}, {31'd0, rd && !tmo});
    chk("done_berr", {31'd0, bus_err}, {31'd0, tmo});
    chk("done_rdata", rdata_out, m_rdata);
    chk("done_addr", addr_out, m_addr_out);
    chk("done_size", {30'd0, size_out}, {30'd0, m_size});
    chk("done_sign", {31'd0, sign_out}, {31'd0, m_sign});
    chk_held("done");
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("idle_lv", {31'd0, load_valid}, 32'd0);
    chk("idle_berr", {31'd0, bus_err}, 32'd0);
    chk("idle_aerr", {31'd0, addr_err}, 32'd0);
    chk("idle_stall0", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; size_in = 0; sign_in = 0;
    addr_in = 0; wdata_in = 0; mem_rdata = 0; mem_ack = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall0", {31'd0, stall}, 32'd0);
    chk("rst_mem_req0", {31'd0, mem_req}, 32'd0);
    chk("rst_rdata0", rdata_out, 32'd0);
    chk_held("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // sb 0x1003, ack in first REQ cycle
    access(0, 1, 2'b00, 0, 32'h1003, 32'h0000_00AB, 32'h0, 1, 0);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_be", {28'd0, mem_be}, 32'h8);
    // lh signed 0x1002, ack in third REQ cycle
    access(1, 0, 2'b01, 1, 32'h1002, 32'h0, 32'h8001_1234, 3, 0);
    chk("lh_rdata", rdata_out, 32'h8001_1234);
    idle_cycle();
    // misaligned word and read+write collisions
    access(1, 0, 2'b10, 0, 32'h1001, 32'h0, 32'h0, 1, 0);
    access(1, 1, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, 0);
    access(0, 1, 2'b01, 0, 32'h1005, 32'h0, 32'h0, 1, 0);
    // timeout, then ack in the last permitted cycle
    access(1, 0, 2'b10, 0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 0, 0);
    access(1, 0, 2'b10, 0, 32'h4004, 32'h0, 32'h1357_9BDF, TMO, 0);
    // reset in the second REQ cycle, then a clean lw
    access(1, 0, 2'b10, 0, 32'h5000, 32'h0, 32'h0, 0, 2);
    access(1, 0, 2'b10, 0, 32'h2000, 32'h0, 32'hCAFE_F00D, 1, 0);
    // back-to-back lbu then sw
    access(1, 0, 2'b00, 0, 32'h3001, 32'h0, 32'h0000_5A00, 1, 0);
    access(0, 1, 2'b10, 0, 32'h3004, 32'h1122_3344, 32'h0, 2, 0);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      logic rd, wr;
      int sel, ackc;
      sel  = $urandom_range(0, 9);
      rd   = (sel < 5) || (sel == 9);
      wr   = (sel >= 5);
      ackc = $urandom_range(0, TMO + 2);
      access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, ackc, 0);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
